add_wide_seq: RTL and testbench
===============================

// Module: add_wide_seq
// PURPOSE
//  Multi-cycle sequencer that performs one LIMBS*WORD_W-bit addition using a
//  single WORD_W-bit adder datapath, processing one limb per cycle from LSB to
//  MSB and chaining the carry through a register. It sits beside adder_32bit as
//  the controller for wide operands (e.g. 128-bit counters and checksums).
//  The input and output sides each use a valid/ready handshake. One operation
//  is in flight at a time.
// PARAMETERS
//  WORD_W  32  width of one limb (datapath adder width)
//  LIMBS   4   limbs per operand, >=1; operand width = LIMBS*WORD_W
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous reset, active-high
//  in_valid   in   1               operands presented
//  in_ready   out  1               sequencer can accept (IDLE only)
//  in_a       in   LIMBS*WORD_W    operand A
//  in_b       in   LIMBS*WORD_W    operand B
//  in_cin     in   1               carry-in to limb 0
//  out_valid  out  1               result available
//  out_ready  in   1               consumer accepts result
//  out_sum    out  LIMBS*WORD_W    sum, limb i = bits [i*WORD_W +: WORD_W]
//  out_cout   out  1               carry-out of the top limb
//  busy       out  1               high in RUN or DONE
// BEHAVIOUR
//  - Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
//  - Reset values: state=IDLE, out_valid=0, out_sum=0, out_cout=0, busy=0.
//    Internally, limb index=0 and carry=0.
//  - Reset mid-operation aborts the operation. No partial result is ever presented.
//  - FSM IDLE:
//    - in_ready=1.
//    - On in_valid&&in_ready: register in_a and in_b, set carry=in_cin,
//      set idx=0, then go to RUN.
//  - FSM RUN:
//    - in_ready=0.
//    - Each cycle: {c,s} = a[idx] + b[idx] + carry, using a (WORD_W+1)-bit add.
//    - out_sum[idx] <= s, carry <= c, idx <= idx+1.
//    - On the cycle where idx==LIMBS-1: set out_cout <= c, then go to DONE.
//  - FSM DONE:
//    - out_valid=1.
//    - out_sum and out_cout stay stable until out_valid&&out_ready.
//    - On that handshake: out_valid <= 0, then go to IDLE.
//  - Latency: out_valid rises exactly LIMBS cycles after the accepting edge.
//  - Throughput: the minimum accept-to-accept spacing is LIMBS+2 cycles
//    (accept, LIMBS RUN edges, DONE handshake edge, then IDLE). Input is never
//    accepted in RUN or DONE.
//  - in_valid while busy: ignored. Operands are not sampled and in_ready stays 0.
//  - Sum arithmetic: modulo 2^(LIMBS*WORD_W). Any carry beyond the top limb
//    goes only to out_cout.
//  - out_sum limbs not yet written in RUN keep their previous values. They are
//    don't-care while out_valid=0.
//  - LIMBS=1: RUN lasts one cycle. The idx register is clog2(LIMBS) bits wide,
//    minimum 1 bit.
//  - out_ready high outside DONE has no effect.
// TESTING  (WORD_W=32, LIMBS=4)
//  1. Carry through all limbs: a=2^128-1, b=1, cin=0
//     -> sum=0, cout=1; out_valid 4 cycles after accept.
//  2. Carry into limb 1: a=0x...0000_FFFFFFFF, b=1, cin=0
//     -> sum=0x...0001_00000000, cout=0.
//  3. Carry-in only: a=0, b=0, cin=1 -> sum=1, cout=0.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE
//     -> out_valid, out_sum and out_cout held; in_ready=0;
//        in_valid pulses are ignored.
//  5. Reset mid-operation: assert rst after 2 RUN cycles
//     -> out_valid=0, in_ready=1 after release; next op a=5, b=7
//        -> sum=12.
//  6. Back-to-back: out_ready tied 1, in_valid held 1
//     -> accepts spaced exactly 6 cycles apart, each result correct.

Source files
------------

// File: rtl/add_wide_seq.sv
// add_wide_seq
//   Adds two LIMBS*WORD_W-bit operands with one WORD_W-bit adder. One limb is
//   added per clock, least significant limb first, and the carry between limbs
//   is held in a register. Only one addition is in flight at a time.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active-high
//     in_valid   operands presented
//     in_ready   high only while idle; an operation starts on in_valid&&in_ready
//     in_a       operand A (LIMBS*WORD_W bits)
//     in_b       operand B (LIMBS*WORD_W bits)
//     in_cin     carry into limb 0
//     out_valid  result available; held until out_valid&&out_ready
//     out_ready  consumer accepts the result
//     out_sum    sum modulo 2^(LIMBS*WORD_W); limb i = bits [i*WORD_W +: WORD_W]
//     out_cout   carry out of the top limb
//     busy       high while an operation is running or waiting to be taken
module add_wide_seq #(
    parameter int WORD_W = 32,
    parameter int LIMBS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LIMBS*WORD_W-1:0]   in_a,
    input  logic [LIMBS*WORD_W-1:0]   in_b,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LIMBS*WORD_W-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      busy
);

    localparam int W     = LIMBS * WORD_W;
    // A single-limb build still needs a one-bit index register.
    localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic                carry;
    logic [IDX_W-1:0]    idx;

    logic [WORD_W-1:0]   a_limb;
    logic [WORD_W-1:0]   b_limb;
    logic [WORD_W:0]     limb_sum;

    // The shared datapath adder. Its extra top bit is the carry into the
    // next limb, or the final carry-out when the top limb is being added.
    always_comb begin
        a_limb   = a_reg[idx*WORD_W +: WORD_W];
        b_limb   = b_reg[idx*WORD_W +: WORD_W];
        limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + {{WORD_W{1'b0}}, carry};
    end

    // Handshake and status flags depend only on the state register, so they
    // carry no combinational path from any input.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Controller and result registers. The operands are captured on accept,
    // so in_a/in_b may change freely while the operation runs. Any activity on
    // in_valid outside IDLE, or on out_ready outside DONE, is ignored. A reset
    // in the middle of a run drops the partial result because out_valid only
    // rises once the top limb has been written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    out_sum[idx*WORD_W +: WORD_W] <= limb_sum[WORD_W-1:0];
                    carry <= limb_sum[WORD_W];
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_cout  <= limb_sum[WORD_W];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_wide_seq.sv
// tb_add_wide_seq
//   Self-checking bench for add_wide_seq (WORD_W=32, LIMBS=4). Expected sums
//   come from plain (W+1)-bit arithmetic on the full operands.
module tb_add_wide_seq;

    localparam int WORD_W = 32;
    localparam int LIMBS  = 4;
    localparam int W      = WORD_W * LIMBS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          busy;

    int errors = 0;
    int checks = 0;

    add_wide_seq #(.WORD_W(WORD_W), .LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the whole addition in one wide expression.
    function automatic logic [W:0] refSum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
        refSum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] randWide();
        logic [W-1:0] r;
        for (int i = 0; i < LIMBS; i++) r[i*WORD_W +: WORD_W] = $urandom;
        return r;
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits, bounded, until the sequencer is idle and ready.
    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_ready"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    endtask

    // Presents operands for exactly one edge, then drops in_valid.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge until out_valid, with a bound.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Full operation: accept, latency, result, and consumer handshake.
    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
        logic [W:0] exp;
        int         lat;
        exp = refSum(a, b, c);
        waitReady(tag);
        applyStimulus(a, b, c);
        waitResult(lat);
        checkOutput({tag, "_latency"}, (W+1)'(lat), (W+1)'(LIMBS));
        checkOutput({tag, "_sum"}, {1'b0, out_sum}, {1'b0, exp[W-1:0]});
        checkOutput({tag, "_cout"}, {{W{1'b0}}, out_cout}, {{W{1'b0}}, exp[W]});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {{W{1'b0}}, out_valid}, '0);
        checkOutput({tag, "_idle"}, {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] lo_ones;
        logic [W:0]   exp;
        logic [W:0]   expq[$];
        int           lat;
        int           cyc;
        int           last_acc;
        int           n_acc;

        ones     = '1;
        lo_ones  = {{(W-WORD_W){1'b0}}, {WORD_W{1'b1}}};
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_cin   = 1'b0;
        out_ready = 1'b0;

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        checkOutput("rst_out_sum", {1'b0, out_sum}, '0);
        checkOutput("rst_out_cout", {{W{1'b0}}, out_cout}, '0);
        checkOutput("rst_busy", {{W{1'b0}}, busy}, '0);
        checkOutput("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed carry cases");
        runOp("carry_all", ones, {{(W-1){1'b0}}, 1'b1}, 1'b0);
        runOp("carry_limb1", lo_ones, {{(W-1){1'b0}}, 1'b1}, 1'b0);
        runOp("cin_only", '0, '0, 1'b1);
        runOp("max_plus_max", ones, ones, 1'b1);

        $display("[TB] random operands");
        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("rand%0d", i), randWide(), randWide(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] backpressure in DONE");
        in_a = randWide();
        in_b = randWide();
        exp  = refSum(in_a, in_b, 1'b1);
        waitReady("bp");
        applyStimulus(in_a, in_b, 1'b1);
        waitResult(lat);
        checkOutput("bp_latency", (W+1)'(lat), (W+1)'(LIMBS));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            in_a     = randWide();
            in_b     = randWide();
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_valid%0d", k), {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
            checkOutput($sformatf("bp_sum%0d", k), {1'b0, out_sum}, {1'b0, exp[W-1:0]});
            checkOutput($sformatf("bp_cout%0d", k), {{W{1'b0}}, out_cout}, {{W{1'b0}}, exp[W]});
            checkOutput($sformatf("bp_in_ready%0d", k), {{W{1'b0}}, in_ready}, '0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp_release", {{W{1'b0}}, out_valid}, '0);
        checkOutput("bp_not_busy", {{W{1'b0}}, busy}, '0);

        $display("[TB] reset mid-operation");
        waitReady("mid");
        applyStimulus(randWide(), randWide(), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {{W{1'b0}}, out_valid}, '0);
        checkOutput("mid_rst_busy", {{W{1'b0}}, busy}, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_after_valid", {{W{1'b0}}, out_valid}, '0);
        checkOutput("mid_after_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        runOp("after_rst", W'(5), W'(7), 1'b0);

        $display("[TB] back-to-back streaming");
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_acc  = -1;
        n_acc     = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (expq.size() > 0) begin
                    exp = expq.pop_front();
                    checkOutput("b2b_sum", {out_cout, out_sum}, exp);
                end else begin
                    checkOutput("b2b_spurious", {{W{1'b0}}, out_valid}, '0);
                end
            end
            in_a   = randWide();
            in_b   = randWide();
            in_cin = 1'($urandom_range(0, 1));
            if (in_ready === 1'b1) begin
                expq.push_back(refSum(in_a, in_b, in_cin));
                if (last_acc >= 0) begin
                    checkOutput("b2b_spacing", (W+1)'(cyc - last_acc), (W+1)'(LIMBS + 2));
                end
                last_acc = cyc;
                n_acc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int d = 0; d < 20 && expq.size() > 0; d++) begin
            if (out_valid === 1'b1) begin
                exp = expq.pop_front();
                checkOutput("b2b_drain_sum", {out_cout, out_sum}, exp);
            end
            @(negedge clk);
        end
        checkOutput("b2b_all_done", (W+1)'(expq.size()), '0);
        checkOutput("b2b_accepts", (W+1)'(n_acc), (W+1)'(7));
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
